// File: rtl/udp_decoder.sv
// UDP receive decoder: header field extraction, payload forwarding and
// one's-complement checksum verification over a 32-bit word stream.
module udp_decoder #(
   parameter int DATA_W     = 32,
   parameter int PKT_ADDR_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_valid,
   output logic [PKT_ADDR_W-1:0] src_port,
   output logic [PKT_ADDR_W-1:0] dest_port,
   output logic [PKT_ADDR_W-1:0] len,
   output logic [PKT_ADDR_W-1:0] chksum_rx,
   output logic [DATA_W-1:0]     pay_data,
   output logic                  pay_valid,
   output logic                  fin,
   output logic                  chksum_ok,
   output logic                  no_chksum,
   output logic                  err_len
);

   typedef enum logic [2:0] {
      IDLE,
      HDR_1,
      HDR_2,
      DATA,
      FIN
   } state_t;

   state_t state_q, state_d;

   logic [15:0] src_q, src_d;
   logic [15:0] dest_q, dest_d;
   logic [15:0] len_q, len_d;
   logic [15:0] chk_q, chk_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] left_q, left_d;
   logic [31:0] pdata_q, pdata_d;
   logic        pvalid_q, pvalid_d;
   logic        ok_q, ok_d;
   logic        noc_q, noc_d;
   logic        err_q, err_d;
   logic [15:0] l_field;

   function automatic logic [15:0] oc_add(
      input logic [15:0] a,
      input logic [15:0] b
   );
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

   function automatic logic [15:0] oc_word(
      input logic [15:0] a,
      input logic [31:0] w
   );
      return oc_add(oc_add(a, w[31:16]), w[15:0]);
   endfunction

   assign l_field = in_data[31:16];

   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dest_d   = dest_q;
      len_d    = len_q;
      chk_d    = chk_q;
      acc_d    = acc_q;
      left_d   = left_q;
      pdata_d  = pdata_q;
      pvalid_d = 1'b0;
      ok_d     = ok_q;
      noc_d    = noc_q;
      err_d    = err_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HDR_1;
               acc_d   = 16'd0;
               ok_d    = 1'b0;
               noc_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         HDR_1: begin
            if (in_valid) begin
               src_d   = in_data[31:16];
               dest_d  = in_data[15:0];
               acc_d   = oc_word(acc_q, in_data);
               state_d = HDR_2;
            end
         end
         HDR_2: begin
            if (in_valid) begin
               chk_d = in_data[15:0];
               acc_d = oc_word(acc_q, in_data);
               if (l_field < 16'd8) begin
                  err_d   = 1'b1;
                  len_d   = 16'd0;
                  left_d  = 16'd0;
                  state_d = FIN;
               end else begin
                  len_d   = l_field - 16'd8;
                  left_d  = l_field - 16'd8;
                  state_d = (l_field == 16'd8) ? FIN : DATA;
               end
            end
         end
         DATA: begin
            if (in_valid) begin
               pdata_d  = in_data;
               pvalid_d = 1'b1;
               acc_d    = oc_word(acc_q, in_data);
               left_d   = (left_q < 16'd4) ? 16'd0 : left_q - 16'd4;
               if (left_q <= 16'd4) begin
                  state_d = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // status is resolved on entry to FIN so it is valid alongside fin
      if (state_d == FIN && state_q != FIN) begin
         noc_d = (chk_d == 16'd0);
         ok_d  = (noc_d | (acc_d == 16'hFFFF)) & ~err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         src_q    <= '0;
         dest_q   <= '0;
         len_q    <= '0;
         chk_q    <= '0;
         acc_q    <= '0;
         left_q   <= '0;
         pdata_q  <= '0;
         pvalid_q <= 1'b0;
         ok_q     <= 1'b0;
         noc_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dest_q   <= dest_d;
         len_q    <= len_d;
         chk_q    <= chk_d;
         acc_q    <= acc_d;
         left_q   <= left_d;
         pdata_q  <= pdata_d;
         pvalid_q <= pvalid_d;
         ok_q     <= ok_d;
         noc_q    <= noc_d;
         err_q    <= err_d;
      end
   end

   assign src_port  = src_q;
   assign dest_port = dest_q;
   assign len       = len_q;
   assign chksum_rx = chk_q;
   assign pay_data  = pdata_q;
   assign pay_valid = pvalid_q;
   assign fin       = (state_q == FIN);
   assign chksum_ok = ok_q;
   assign no_chksum = noc_q;
   assign err_len   = err_q;

endmodule

// File: tb/tb_udp_decoder.sv
// Directed bench for udp_decoder: table of whole packets plus
// hand-written stall, start-while-busy and reset sequences.
module tb_udp_decoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] in_data;
   logic        in_valid;
   logic [15:0] src_port, dest_port, len, chksum_rx;
   logic [31:0] pay_data;
   logic        pay_valid, fin, chksum_ok, no_chksum, err_len;

   udp_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .src_port  (src_port),
      .dest_port (dest_port),
      .len       (len),
      .chksum_rx (chksum_rx),
      .pay_data  (pay_data),
      .pay_valid (pay_valid),
      .fin       (fin),
      .chksum_ok (chksum_ok),
      .no_chksum (no_chksum),
      .err_len   (err_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int          npay;
   int          nfin;
   logic [31:0] last_pay;
   logic        fin_ok, fin_noc, fin_err;

   typedef struct {
      string       name;
      logic [31:0] w [4];
      int          nw;
      logic [15:0] e_src;
      logic [15:0] e_dest;
      logic [15:0] e_len;
      logic        e_ok;
      logic        e_noc;
      logic        e_err;
      int          e_npay;
      logic [31:0] e_pay;
   } vec_t;

   vec_t vecs [4];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (pay_valid) begin
         npay++;
         last_pay = pay_data;
      end
      if (fin) begin
         nfin++;
         fin_ok  = chksum_ok;
         fin_noc = no_chksum;
         fin_err = err_len;
      end
   endtask

   task automatic clr_mon();
      npay     = 0;
      nfin     = 0;
      last_pay = '0;
      fin_ok   = 1'b0;
      fin_noc  = 1'b0;
      fin_err  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int fin_at_last;
      clr_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      fin_at_last = 0;
      for (int i = 0; i < v.nw; i++) begin
         in_data  = v.w[i];
         in_valid = 1'b1;
         tick();
         if (i == v.nw - 1 && fin) fin_at_last = 1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      for (int i = 0; i < 3; i++) tick();
      chk({v.name, " src"}, {16'd0, src_port}, {16'd0, v.e_src});
      chk({v.name, " dest"}, {16'd0, dest_port}, {16'd0, v.e_dest});
      chk({v.name, " len"}, {16'd0, len}, {16'd0, v.e_len});
      chk({v.name, " nfin"}, nfin, 1);
      chk({v.name, " fin_at_last"}, fin_at_last, 1);
      chk({v.name, " npay"}, npay, v.e_npay);
      chk({v.name, " pay_data"}, last_pay, v.e_pay);
      chk({v.name, " ok"}, {31'd0, fin_ok}, {31'd0, v.e_ok});
      chk({v.name, " no_chksum"}, {31'd0, fin_noc}, {31'd0, v.e_noc});
      chk({v.name, " err_len"}, {31'd0, fin_err}, {31'd0, v.e_err});
      chk({v.name, " ok_hold"}, {31'd0, chksum_ok}, {31'd0, v.e_ok});
   endtask

   function automatic logic [31:0] all_outs();
      return {src_port ^ dest_port ^ len ^ chksum_rx, 16'd0} ^ pay_data ^
             {27'd0, pay_valid, fin, chksum_ok, no_chksum, err_len};
   endfunction

   initial begin
      int fin_seen;
      int stall_pay;

      vecs[0] = '{"nominal", '{32'h12345678, 32'h000CF9A9, 32'hDEADBEEF, 0},
                  3, 16'h1234, 16'h5678, 16'd4, 1'b1, 1'b0, 1'b0, 1,
                  32'hDEADBEEF};
      vecs[1] = '{"corrupt", '{32'h12345678, 32'h000CF9A9, 32'hDEADBEEE, 0},
                  3, 16'h1234, 16'h5678, 16'd4, 1'b0, 1'b0, 1'b0, 1,
                  32'hDEADBEEE};
      vecs[2] = '{"hdr_only", '{32'h00010002, 32'h00080000, 0, 0},
                  2, 16'h0001, 16'h0002, 16'd0, 1'b1, 1'b1, 1'b0, 0, 32'd0};
      vecs[3] = '{"bad_len", '{32'h00010002, 32'h00041234, 0, 0},
                  2, 16'h0001, 16'h0002, 16'd0, 1'b0, 1'b0, 1'b1, 0, 32'd0};

      reset    = 1'b1;
      start    = 1'b0;
      in_data  = '0;
      in_valid = 1'b0;
      clr_mon();
      tick();
      tick();
      chk("reset outs", all_outs(), 32'd0);
      chk("reset len", {16'd0, len}, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // 7-byte payload with in_valid toggling
      clr_mon();
      stall_pay = 0;
      fin_seen  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h00010002;
      tick();
      in_data  = 32'h000F5587;
      tick();
      in_data  = 32'h11112222;
      tick();
      if (fin) fin_seen = 1;
      in_valid = 1'b0;
      in_data  = 32'hFFFFFFFF;
      tick();
      if (pay_valid) stall_pay++;
      if (fin) fin_seen = 1;
      tick();
      if (pay_valid) stall_pay++;
      if (fin) fin_seen = 1;
      in_valid = 1'b1;
      in_data  = 32'h33334400;
      tick();
      chk("stall fin_after_2nd", {31'd0, fin}, 32'd1);
      chk("stall early_fin", fin_seen, 0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("stall npay", npay, 2);
      chk("stall pay_in_stall", stall_pay, 0);
      chk("stall pay_data", last_pay, 32'h33334400);
      chk("stall len", {16'd0, len}, 32'd7);
      chk("stall chksum_rx", {16'd0, chksum_rx}, 32'h5587);
      chk("stall ok", {31'd0, fin_ok}, 32'd1);
      chk("stall nfin", nfin, 1);

      // start while busy is ignored, then reset mid-DATA
      clr_mon();
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h00010002;
      tick();
      in_data  = 32'h00140000;
      tick();
      in_data  = 32'hAAAA5555;
      tick();
      in_valid = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'h0BADF00D;
      tick();
      chk("busy start pay_valid", {31'd0, pay_valid}, 32'd1);
      chk("busy start pay_data", pay_data, 32'h0BADF00D);
      in_valid = 1'b0;
      reset    = 1'b1;
      tick();
      chk("midreset outs", all_outs(), 32'd0);
      chk("midreset src", {src_port, dest_port}, 32'd0);
      reset = 1'b0;
      tick();
      tick();
      chk("midreset nfin", nfin, 0);

      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/udp_decoder.md
Name: udp_decoder

Overview:
Receive-side counterpart of the UDP packet encoder. Consumes a UDP datagram as a stream of 32-bit words: header word 1, header word 2, then payload. Extracts the header fields, forwards payload words with a valid strobe, and checks the UDP checksum by one's-complement summation (no pseudo-header). Sits between the link-layer word FIFO and the application payload sink.

Parameters:
DATA_W, 32, stream word width; fixed, only 32 is supported.
PKT_ADDR_W, 16, width of the port, length and checksum fields; fixed at 16.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; a new datagram begins; sampled only in IDLE
in_data  input  32  incoming datagram word
in_valid  input  1  in_data holds a word this cycle; low means stall
src_port  output  16  header word 1 [31:16]
dest_port  output  16  header word 1 [15:0]
len  output  16  payload byte count = UDP length field - 8; 0 if the field is < 8
chksum_rx  output  16  header word 2 [15:0]
pay_data  output  32  payload word
pay_valid  output  1  pay_data is valid this cycle
fin  output  1  one-cycle pulse; datagram done, status outputs valid
chksum_ok  output  1  checksum passed, or sender used no checksum; valid with fin
no_chksum  output  1  chksum_rx == 0; valid with fin
err_len  output  1  UDP length field < 8; valid with fin

Behaviour:
- Reset: all outputs and all internal registers go to 0; state goes to IDLE. Reset mid-packet abandons the packet; no fin is produced.
- States: IDLE, HDR_1, HDR_2, DATA, FIN.
- IDLE -> HDR_1 on start. start in any other state is ignored.
- HDR_1: on in_valid, latch src_port and dest_port; go to HDR_2.
- HDR_2: on in_valid, latch length field L and chksum_rx; set bytes_left = L - 8.
  - L < 8: set err_len, go to FIN.
  - L == 8: go to FIN.
  - Otherwise: go to DATA.
- DATA: on each in_valid, pay_data <= in_data, pay_valid = 1 on the next cycle (1-cycle registered latency), and bytes_left <= (bytes_left < 4) ? 0 : bytes_left - 4.
  - Go to FIN when the word that brings bytes_left to 0 is accepted.
  - Cycles with in_valid low: pay_valid = 0, no state change.
- FIN: fin = 1 for exactly one cycle; next state is IDLE.
- Header and status outputs hold their values until the next HDR_1 word overwrites them. The status outputs are cleared when start is accepted.
- Checksum accumulator (16-bit one's-complement add with end-around carry):
  - Cleared on start.
  - Accumulates both halves of every accepted header and payload word: src, dest, L, chksum_rx, then data[31:16] and data[15:0].
  - Payload bytes beyond L in the final word are included as-is; the sender zero-pads them.
- At FIN:
  - no_chksum = (chksum_rx == 0).
  - chksum_ok = no_chksum | (acc == 16'hFFFF), forced to 0 when err_len is set.
- Words arriving outside HDR_1/HDR_2/DATA are ignored. Words arriving while in FIN are dropped.

Test Plan:
- Nominal: start; words 0x12345678, 0x000CF9A9, 0xDEADBEEF -> src 0x1234, dest 0x5678, len 4; pay_data 0xDEADBEEF with pay_valid for 1 cycle; fin; chksum_ok 1, no_chksum 0, err_len 0.
- Corrupt payload: same packet with data 0xDEADBEEE -> fin with chksum_ok 0.
- No checksum and header-only: words 0x00010002, 0x00080000 -> len 0, no pay_valid, fin right after HDR_2, no_chksum 1, chksum_ok 1.
- Stalls and partial last word: L = 0x000F (7 payload bytes), in_valid toggled 1/0 -> exactly 2 pay_valid pulses, fin after the 2nd data word, no pay_valid during stall cycles.
- Bad length: L = 0x0004 -> err_len 1, chksum_ok 0, fin, return to IDLE.
- Reset mid-DATA and start-while-busy: a start pulse in DATA has no effect; reset asserted in DATA -> all outputs 0, no fin; the next packet decodes correctly.
